// File: rtl/shift_sequencer.sv
// Full-duplex serial sequencer for the universal shift register: load a word, shift N bits, return the result.
// Optional bit-period prescaler compiled in with SHIFT_SEQ_PRESCALE_EN (period DIV clocks).
`timescale 1ns/1ps
module shift_sequencer #(
  parameter int N   = 8,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_dir,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         ser_out,
  input  logic         ser_in,
  output logic         ser_strobe,
  output logic         busy,
  output logic [1:0]   sr_s,
  output logic [N-1:0] sr_d,
  output logic         sr_lin,
  output logic         sr_rin,
  input  logic [N-1:0] sr_q
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  if (N < 2 || DIV < 2) begin : g_param_check
    $error("shift_sequencer: N and DIV must both be at least 2");
  end

  state_t         state_q, state_d;
  logic           dir_q, dir_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   sr_d_q, sr_d_d;
  logic           strobe;

`ifdef SHIFT_SEQ_PRESCALE_EN
  localparam int PW = $clog2(DIV);
  logic [PW-1:0] pre_q, pre_d;

  // Held at zero outside SHIFT so every transfer starts a fresh bit period.
  always_comb begin
    pre_d = '0;
    if (state_q == SHIFT) pre_d = (pre_q == PW'(DIV - 1)) ? '0 : pre_q + 1'b1;
  end

  assign strobe = (state_q == SHIFT) && (pre_q == PW'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pre_q <= '0;
    else       pre_q <= pre_d;
  end
`else
  assign strobe = (state_q == SHIFT);
`endif

  // NOTE: every output and next-state value gets a default first so no path leaves a latch.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    sr_d_d     = sr_d_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    sr_s       = 2'b00;
    ser_out    = 1'b0;
    ser_strobe = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = ~reset;
        if (in_valid && !reset) begin
          sr_d_d  = in_data;
          dir_d   = in_dir;
          state_d = LOAD;
        end
      end
      LOAD: begin
        sr_s    = 2'b11;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        ser_out    = dir_q ? sr_q[0] : sr_q[N-1];
        ser_strobe = strobe;
        if (strobe) begin
          sr_s = dir_q ? 2'b01 : 2'b10;
          if (cnt_q == CW'(N - 1)) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      sr_d_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      sr_d_q  <= sr_d_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign sr_d     = sr_d_q;
  assign sr_lin   = ser_in;
  assign sr_rin   = ser_in;
  assign out_data = sr_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: behavioural shift register model plus a scoreboard of
// expected serial bits and returned words, filled at each accepted request.
`timescale 1ns/1ps
module tb_shift_sequencer;

  localparam int N   = 8;
  localparam int DIV = 4;
`ifdef SHIFT_SEQ_PRESCALE_EN
  localparam int BIT_CLKS = DIV;
`else
  localparam int BIT_CLKS = 1;
`endif
  localparam int BUDGET = 400;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, in_dir;
  logic [N-1:0] in_data;
  logic         out_valid, out_ready;
  logic [N-1:0] out_data;
  logic         ser_out, ser_in, ser_strobe, busy;
  logic [1:0]   sr_s;
  logic [N-1:0] sr_d;
  logic         sr_lin, sr_rin;
  logic [N-1:0] sr_q = '0;
  logic [1:0]   ser_mode = 2'd0;  // 0 loopback, 1 tie high, 2 tie low

  int total = 0;
  int bad   = 0;

  shift_sequencer #(.N(N), .DIV(DIV)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dir(in_dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ser_out(ser_out), .ser_in(ser_in), .ser_strobe(ser_strobe), .busy(busy),
    .sr_s(sr_s), .sr_d(sr_d), .sr_lin(sr_lin), .sr_rin(sr_rin), .sr_q(sr_q)
  );

  always #5 clk = ~clk;

  assign ser_in = (ser_mode == 2'd0) ? ser_out : ser_mode[0];

  // Universal shift register datapath driven by the sequencer.
  always @(posedge clk) begin
    case (sr_s)
      2'b01:   sr_q <= {sr_rin, sr_q[N-1:1]};
      2'b10:   sr_q <= {sr_q[N-2:0], sr_lin};
      2'b11:   sr_q <= sr_d;
      default: sr_q <= sr_q;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard state
  logic [N-1:0] exp_q[$];
  logic         bit_q[$];
  int  edge_n = 0;
  int  acc_edge = 0;
  int  prev_acc = 0;
  bit  prev_valid = 1'b0;
  bit  btb = 1'b0;
  bit  cur_dir = 1'b0;
  bit  ov_prev = 1'b0;
  int  shift_cnt = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    if (reset) begin
      ov_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        acc_edge = edge_n + 1;
        if (btb && prev_valid) check("accept_period", acc_edge - prev_acc, N * BIT_CLKS + 3);
        prev_acc   = acc_edge;
        prev_valid = 1'b1;
        cur_dir    = in_dir;
        shift_cnt  = 0;
        for (int i = 0; i < N; i++) bit_q.push_back(in_dir ? in_data[i] : in_data[N-1-i]);
        case (ser_mode)
          2'd0:    exp_q.push_back(in_data);
          2'd1:    exp_q.push_back('1);
          default: exp_q.push_back('0);
        endcase
      end
      if (busy && !out_valid && sr_s != 2'b11) begin
        shift_cnt++;
        if (bit_q.size() == 0) check("bitq_empty", 0, 1);
        else                   check("ser_out", ser_out, bit_q[0]);
        if (ser_strobe) begin
          check("strobe_gap", shift_cnt, BIT_CLKS);
          check("sr_s_shift", sr_s, cur_dir ? 2'b01 : 2'b10);
          if (bit_q.size() != 0) void'(bit_q.pop_front());
          shift_cnt = 0;
        end else begin
          check("sr_s_between", sr_s, 2'b00);
        end
      end
      // Latency counted in edges including the accept edge itself.
      if (out_valid && !ov_prev) check("latency", edge_n - acc_edge + 1, N * BIT_CLKS + 2);
      if (out_valid && out_ready) begin
        check("done_sr_s", sr_s, 2'b00);
        if (exp_q.size() == 0) check("expq_empty", 0, 1);
        else                   check("out_data", out_data, exp_q.pop_front());
        check("bits_left", bit_q.size(), 0);
      end
      ov_prev = out_valid;
    end
  end

  task automatic send(input logic [N-1:0] d, input logic dr);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dr;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~d;
    in_dir   = ~dr;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < BUDGET; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    check("done_timeout", exp_q.size(), 0);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_dir = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sr_s", sr_s, 0);
    check("rst_sr_d", sr_d, 0);
    check("rst_strobe", ser_strobe, 0);
    check("rst_ser_out", ser_out, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);

    // MSB first with loopback returns the same word.
    ser_mode = 2'd0; send(8'hA5, 1'b0); wait_done();
    // LSB first with ser_in tied high fills with ones.
    ser_mode = 2'd1; send(8'h01, 1'b1); wait_done();
    ser_mode = 2'd2; send(8'h5B, 1'b0); wait_done();
    ser_mode = 2'd0; send(8'hC3, 1'b1); wait_done();

    // Back-pressure in DONE: everything holds, requests ignored.
    ser_mode = 2'd0; out_ready = 1'b0;
    send(8'h3C, 1'b0);
    for (int i = 0; i < BUDGET && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, (exp_q.size() != 0) ? exp_q[0] : '0);
      check("stall_sr_s", sr_s, 0);
      check("stall_in_ready", in_ready, 0);
      @(posedge clk); #1;
      in_valid = i[0];
      in_data  = N'($urandom);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_done();

    // Back-to-back with in_valid and out_ready held high.
    btb = 1'b1; prev_valid = 1'b0;
    in_valid = 1'b1;
    for (int w = 0; w < 4; w++) begin
      bit ok = 1'b0;
      in_data = N'($urandom);
      in_dir  = w[0];
      for (int i = 0; i < BUDGET; i++) begin
        @(negedge clk);
        if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) check("btb_timeout", 0, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_done();
    btb = 1'b0;

    // Reset part way through SHIFT abandons the transfer.
    ser_mode = 2'd0;
    send(8'h96, 1'b0);
    begin
      int n = 0;
      for (int i = 0; i < BUDGET && n < 3; i++) begin
        @(negedge clk);
        if (ser_strobe) n++;
      end
      check("mid_strobes", n, 3);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    bit_q.delete();
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_sr_s", sr_s, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_out_valid", out_valid, 0);
    end
    send(8'h69, 1'b1); wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Sequencing controller for the team's parameterised universal shift register (modes: 00 hold, 01 shift right, 10 shift left, 11 parallel load). It accepts a parallel word over a valid/ready handshake and loads it into the register. It then issues exactly N shift commands in the requested direction, presenting the outgoing serial bit while capturing the incoming serial bit, and returns the received word over a second valid/ready handshake. It is the full-duplex serial engine placed between a register-file/bus client and the shift-register datapath.

## Interface

- N, 8, shift register width; N ≥ 2
- DIV, 4, bit period in clocks when prescaling is compiled in; DIV ≥ 2; ignored otherwise
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  request word valid
- in_ready  out  1  controller can accept a request
- in_data  in  N  word to transmit
- in_dir  in  1  0 = MSB first (shift left), 1 = LSB first (shift right); sampled on accept
- out_valid  out  1  received word available
- out_ready  in  1  consumer accepts received word
- out_data  out  N  received word; equals sr_q while out_valid
- ser_out  out  1  outgoing serial bit
- ser_in  in  1  incoming serial bit
- ser_strobe  out  1  high in each cycle whose closing edge shifts the register
- busy  out  1  high in any state other than IDLE
- sr_s  out  2  mode command to shift register
- sr_d  out  N  parallel load value
- sr_lin  out  1  serial input for left shift
- sr_rin  out  1  serial input for right shift
- sr_q  in  N  shift register contents

## Operation

- States: IDLE, LOAD, SHIFT, DONE. Reset forces IDLE from any state, including mid-transfer; no partial result is emitted.
- Reset values: in_ready=0 during reset, 1 once in IDLE; out_valid=0, ser_strobe=0, busy=0, sr_s=00, sr_d=0, internal dir=0, bit counter=0.
- IDLE: in_ready=1, sr_s=00. When in_valid&&in_ready, register in_data into sr_d and in_dir into dir, then go to LOAD.
- LOAD (1 cycle): sr_s=11, then go to SHIFT with bit counter=0.
- SHIFT: sr_s=10 (dir=0) or 01 (dir=1) on strobe cycles, 00 otherwise. ser_out = sr_q[N-1] (dir=0) or sr_q[0] (dir=1). sr_lin = sr_rin = ser_in. The counter increments on each strobe. The strobe with counter=N-1 moves the FSM to DONE.
- DONE: sr_s=00, out_valid=1, out_data=sr_q. On out_valid&&out_ready, go to IDLE.
- Outside SHIFT, ser_out holds 0.
- in_valid is ignored while busy. in_data and in_dir changes after accept have no effect.
- Counter width is $clog2(N) bits. It never wraps within a transfer.

## Timing

- Without prescale: ser_strobe=1 in every SHIFT cycle; bit k is driven on ser_out in SHIFT cycle k; ser_in is sampled at that cycle's closing edge.
- out_valid rises N+2 edges after the accept edge. With prescale, this is N·DIV+2.
- Minimum request-to-request period is N+3 cycles when out_ready is held high.
- out_valid and out_data stay stable until out_ready. Back-pressure may last indefinitely.
- in_ready is 0 from the cycle after accept until the cycle after the DONE handshake.

## Configuration

- SHIFT_SEQ_PRESCALE_EN defined: a DIV-cycle prescale counter runs in SHIFT. ser_strobe and the shift command are asserted only in the last cycle of each DIV-cycle bit period, and ser_out is stable for the full period. The prescale counter resets to 0 on entering SHIFT and on reset.
- SHIFT_SEQ_PRESCALE_EN undefined: there is no prescale logic, one bit is shifted per clock, and DIV is unused.

## Test plan

- Reset mid-SHIFT (after 3 bits): the next cycle shows busy=0, sr_s=00, out_valid=0. The FSM stays in IDLE, and a fresh request then completes normally.
- N=8, in_data=8'hA5, dir=0, ser_in looped from ser_out: ser_out sequence 1,0,1,0,0,1,0,1. out_valid rises 10 edges after accept, with out_data=8'hA5.
- N=8, in_data=8'h01, dir=1, ser_in tied 1: ser_out sequence 1,0,0,0,0,0,0,0, then out_data=8'hFF.
- out_ready held 0 for 20 cycles in DONE: out_valid and out_data stay stable, sr_s=00, in_ready=0, and in_valid pulses are ignored.
- Back-to-back requests with in_valid and out_ready tied 1: accepts occur every 11 cycles, and each word is returned intact.
- With SHIFT_SEQ_PRESCALE_EN and DIV=4: ser_strobe pulses every 4th SHIFT cycle, each ser_out bit lasts 4 cycles, and out_valid rises 34 edges after accept.
